// File: rtl/mem_lsu.sv
// MIPS memory-access stage: registers EX/MEM fields, runs a req/ack data-memory port (big-endian).
// Define MEM_ALIGN_CHECK_EN to trap misaligned halfword/word accesses instead of issuing them.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        wreg_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] mem_addr_i,
  output logic        stall_req_o,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [3:0]  dm_sel_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_ack_i,
  input  logic [31:0] dm_rdata_i,
  output logic        wreg_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        align_err_o
);

  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpLh  = 8'b1110_0001;
  localparam logic [7:0] OpLhu = 8'b1110_0101;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpSb  = 8'b1110_1000;
  localparam logic [7:0] OpSh  = 8'b1110_1001;
  localparam logic [7:0] OpSw  = 8'b1110_1011;

  typedef enum logic {StIdle, StAccess} state_e;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {OpLb, OpLbu, OpLh, OpLhu, OpLw};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {OpSb, OpSh, OpSw};
  endfunction

  function automatic logic is_mem(input logic [7:0] op);
    return is_load(op) || is_store(op);
  endfunction

  state_e      state_q;
  logic        wreg_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic [7:0]  aluop_q;
  logic [31:0] reg2_q;
  logic [31:0] addr_q;
  logic        wb_wreg_q;
  logic [4:0]  wb_waddr_q;
  logic [31:0] wb_wdata_q;
  logic        align_err_q;

  logic        in_access;
  logic        mis_in;
  logic        start_access;
  logic [3:0]  sel;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] a);
    return ((op inside {OpLh, OpLhu, OpSh}) && a[0]) ||
           ((op inside {OpLw, OpSw}) && (a != 2'b00));
  endfunction

  assign mis_in = misaligned(aluop_i, mem_addr_i[1:0]);
`else
  assign mis_in = 1'b0;
`endif

  assign in_access    = (state_q == StAccess);
  assign start_access = is_mem(aluop_i) && !mis_in;
  // Combinational on ack so the op queued behind the access is captured on the ack edge.
  assign stall_req_o  = in_access && !dm_ack_i;

  always_comb begin
    sel     = 4'b1111;
    st_data = reg2_q;
    if (aluop_q inside {OpLb, OpLbu, OpSb}) begin
      sel     = 4'b1000 >> addr_q[1:0];
      st_data = {4{reg2_q[7:0]}};
    end else if (aluop_q inside {OpLh, OpLhu, OpSh}) begin
      sel     = addr_q[1] ? 4'b0011 : 4'b1100;
      st_data = {2{reg2_q[15:0]}};
    end
  end

  always_comb begin
    ld_byte = 8'h00;
    unique case (addr_q[1:0])
      2'b00: ld_byte = dm_rdata_i[31:24];
      2'b01: ld_byte = dm_rdata_i[23:16];
      2'b10: ld_byte = dm_rdata_i[15:8];
      2'b11: ld_byte = dm_rdata_i[7:0];
    endcase
    ld_half = addr_q[1] ? dm_rdata_i[15:0] : dm_rdata_i[31:16];
    case (aluop_q)
      OpLb:    ld_result = {{24{ld_byte[7]}}, ld_byte};
      OpLbu:   ld_result = {24'h0, ld_byte};
      OpLh:    ld_result = {{16{ld_half[15]}}, ld_half};
      OpLhu:   ld_result = {16'h0, ld_half};
      default: ld_result = dm_rdata_i;
    endcase
  end

  assign dm_req_o    = in_access;
  assign dm_we_o     = in_access && is_store(aluop_q);
  assign dm_addr_o   = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dm_sel_o    = in_access ? sel : 4'b0000;
  assign dm_wdata_o  = in_access ? st_data : 32'h0;
  assign wreg_o      = wb_wreg_q;
  assign waddr_o     = wb_waddr_q;
  assign wdata_o     = wb_wdata_q;
  // Stays 0 when the alignment check is compiled out, since mis_in is then constant 0.
  assign align_err_o = align_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wreg_q      <= 1'b0;
      waddr_q     <= 5'd0;
      wdata_q     <= 32'h0;
      aluop_q     <= 8'h0;
      reg2_q      <= 32'h0;
      addr_q      <= 32'h0;
      wb_wreg_q   <= 1'b0;
      wb_waddr_q  <= 5'd0;
      wb_wdata_q  <= 32'h0;
      align_err_q <= 1'b0;
    end else begin
      if (!stall_req_o) begin
        wreg_q      <= wreg_i;
        waddr_q     <= waddr_i;
        wdata_q     <= wdata_i;
        aluop_q     <= aluop_i;
        reg2_q      <= reg2_i;
        addr_q      <= mem_addr_i;
        align_err_q <= is_mem(aluop_i) && mis_in;
        state_q     <= start_access ? StAccess : StIdle;
      end else begin
        align_err_q <= 1'b0;
      end

      // Default is a bubble; only pass-through ops and acknowledged loads write back.
      wb_wreg_q  <= 1'b0;
      wb_waddr_q <= 5'd0;
      wb_wdata_q <= 32'h0;
      unique case (state_q)
        StIdle: begin
          // A memory op idling in the stage was rejected as misaligned.
          if (!is_mem(aluop_q)) begin
            wb_wreg_q  <= wreg_q;
            wb_waddr_q <= waddr_q;
            wb_wdata_q <= wdata_q;
          end
        end
        StAccess: begin
          if (dm_ack_i && is_load(aluop_q)) begin
            wb_wreg_q  <= wreg_q;
            wb_waddr_q <= waddr_q;
            wb_wdata_q <= ld_result;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: stimulus queues expected write-backs and memory requests,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_lsu;

  localparam logic [7:0] OpNop = 8'h00;
  localparam logic [7:0] OpAdd = 8'b0010_0000;
  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpLh  = 8'b1110_0001;
  localparam logic [7:0] OpLhu = 8'b1110_0101;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpSb  = 8'b1110_1000;
  localparam logic [7:0] OpSh  = 8'b1110_1001;
  localparam logic [7:0] OpSw  = 8'b1110_1011;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        adj;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        chk_wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wreg_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg2_i;
  logic [31:0] mem_addr_i;
  logic        stall_req_o;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_sel_o;
  logic [31:0] dm_wdata_o;
  logic        dm_ack_i;
  logic [31:0] dm_rdata_i;
  logic        wreg_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        align_err_o;

  wb_t  wb_q[$];
  req_t req_q[$];
  wb_t  exp_wb;
  req_t exp_req;
  req_t held;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   last_wb = -10;
  int   align_cnt = 0;
  int   st;
  logic prev_pending = 1'b0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk         (clk),
    .rst         (rst),
    .wreg_i      (wreg_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .aluop_i     (aluop_i),
    .reg2_i      (reg2_i),
    .mem_addr_i  (mem_addr_i),
    .stall_req_o (stall_req_o),
    .dm_req_o    (dm_req_o),
    .dm_we_o     (dm_we_o),
    .dm_addr_o   (dm_addr_o),
    .dm_sel_o    (dm_sel_o),
    .dm_wdata_o  (dm_wdata_o),
    .dm_ack_i    (dm_ack_i),
    .dm_rdata_i  (dm_rdata_i),
    .wreg_o      (wreg_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .align_err_o (align_err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_ex(input logic [7:0] op, input logic wr, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [31:0] r2, input logic [31:0] ad);
    aluop_i    = op;
    wreg_i     = wr;
    waddr_i    = wa;
    wdata_i    = wd;
    reg2_i     = r2;
    mem_addr_i = ad;
  endtask

  task automatic nop();
    set_ex(OpNop, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic send(input logic [7:0] op, input logic wr, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [31:0] r2, input logic [31:0] ad);
    set_ex(op, wr, wa, wd, r2, ad);
    @(posedge clk);
    #1;
    nop();
  endtask

  // Holds ack low for `waits` cycles, counting stall cycles, then acks for one cycle.
  task automatic ack_after(input int waits, input logic [31:0] rd, output int stalls);
    stalls = 0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (stall_req_o) stalls++;
      @(posedge clk);
      #1;
    end
    dm_ack_i   = 1'b1;
    dm_rdata_i = rd;
    @(negedge clk);
    check("stall_low_at_ack", {31'h0, stall_req_o}, 32'h0);
    @(posedge clk);
    #1;
    dm_ack_i   = 1'b0;
    dm_rdata_i = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (align_err_o) align_cnt++;
      if (wreg_o) begin
        if (wb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb: got waddr=%0d wdata=%h, expected no write",
                   waddr_o, wdata_o);
        end else begin
          exp_wb = wb_q.pop_front();
          check("wb_waddr", {27'h0, waddr_o}, {27'h0, exp_wb.waddr});
          check("wb_wdata", wdata_o, exp_wb.wdata);
          if (exp_wb.adj) check("wb_back_to_back", cycle - last_wb, 1);
        end
        last_wb = cycle;
      end
      if (dm_req_o && !prev_pending) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr=%h sel=%b, expected no request",
                   dm_addr_o, dm_sel_o);
        end else begin
          exp_req = req_q.pop_front();
          check("req_we", {31'h0, dm_we_o}, {31'h0, exp_req.we});
          check("req_addr", dm_addr_o, exp_req.addr);
          check("req_sel", {28'h0, dm_sel_o}, {28'h0, exp_req.sel});
          if (exp_req.chk_wdata) check("req_wdata", dm_wdata_o, exp_req.wdata);
        end
        held = '{dm_we_o, dm_addr_o, dm_sel_o, dm_wdata_o, 1'b1};
      end else if (dm_req_o) begin
        check("req_held", {dm_addr_o[31:4], dm_sel_o}, {held.addr[31:4], held.sel});
        check("req_held_wdata", dm_wdata_o, held.wdata);
      end
      prev_pending = dm_req_o && !dm_ack_i;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    dm_ack_i   = 1'b0;
    dm_rdata_i = 32'h0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_wreg", {31'h0, wreg_o}, 32'h0);
    check("rst_waddr", {27'h0, waddr_o}, 32'h0);
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_stall", {31'h0, stall_req_o}, 32'h0);
    check("rst_req", {30'h0, dm_req_o, dm_we_o}, 32'h0);
    check("rst_addr", dm_addr_o, 32'h0);
    check("rst_sel_align", {27'h0, dm_sel_o, align_err_o}, 32'h0);
    check("rst_dm_wdata", dm_wdata_o, 32'h0);
    @(posedge clk);
    #1;

    // ADD pass-through
    wb_q.push_back('{5'd5, 32'h1234_5678, 1'b0});
    send(OpAdd, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 32'h0);
    @(negedge clk);
    check("add_no_stall", {31'h0, stall_req_o}, 32'h0);
    idle(2);

    // LB at 0x1001, ack in the third access cycle
    req_q.push_back('{1'b0, 32'h0000_1000, 4'b0100, 32'h0, 1'b0});
    wb_q.push_back('{5'd7, 32'hFFFF_FF80, 1'b0});
    send(OpLb, 1'b1, 5'd7, 32'h0, 32'h0, 32'h0000_1001);
    ack_after(2, 32'h1180_3344, st);
    check("lb_stall_cycles", st, 2);
    idle(2);

    // SH at 0x2002: store, no write-back even with wreg_i set
    req_q.push_back('{1'b1, 32'h0000_2000, 4'b0011, 32'hBEEF_BEEF, 1'b1});
    send(OpSh, 1'b1, 5'd9, 32'h0, 32'h0000_BEEF, 32'h0000_2002);
    ack_after(1, 32'h0, st);
    check("sh_stall_cycles", st, 1);
    idle(2);

    // LHU at 0x2000 with an ADD queued behind it
    req_q.push_back('{1'b0, 32'h0000_2000, 4'b1100, 32'h0, 1'b0});
    wb_q.push_back('{5'd10, 32'h0000_8001, 1'b0});
    wb_q.push_back('{5'd11, 32'hCAFE_F00D, 1'b1});
    send(OpLhu, 1'b1, 5'd10, 32'h0, 32'h0, 32'h0000_2000);
    set_ex(OpAdd, 1'b1, 5'd11, 32'hCAFE_F00D, 32'h0, 32'h0);
    ack_after(1, 32'h8001_AAAA, st);
    nop();
    idle(3);

    // LH at 0x3002 acked immediately, SB at 0x4003 back-to-back
    req_q.push_back('{1'b0, 32'h0000_3000, 4'b0011, 32'h0, 1'b0});
    req_q.push_back('{1'b1, 32'h0000_4000, 4'b0001, 32'hA5A5_A5A5, 1'b1});
    wb_q.push_back('{5'd12, 32'hFFFF_F00F, 1'b0});
    send(OpLh, 1'b1, 5'd12, 32'h0, 32'h0, 32'h0000_3002);
    set_ex(OpSb, 1'b1, 5'd13, 32'h0, 32'h0000_00A5, 32'h0000_4003);
    ack_after(0, 32'h1234_F00F, st);
    check("lh_stall_cycles", st, 0);
    nop();
    ack_after(1, 32'h0, st);
    idle(2);

    // LBU at 0x4000, long wait
    req_q.push_back('{1'b0, 32'h0000_4000, 4'b1000, 32'h0, 1'b0});
    wb_q.push_back('{5'd14, 32'h0000_009A, 1'b0});
    send(OpLbu, 1'b1, 5'd14, 32'h0, 32'h0, 32'h0000_4000);
    ack_after(3, 32'h9A7B_3C4D, st);
    check("lbu_stall_cycles", st, 3);
    idle(2);

    // SW at 0x5000
    req_q.push_back('{1'b1, 32'h0000_5000, 4'b1111, 32'hDEAD_BEEF, 1'b1});
    send(OpSw, 1'b0, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0000_5000);
    ack_after(0, 32'h0, st);
    idle(2);

    // Reset during an LW access, then a stray ack
    req_q.push_back('{1'b0, 32'h0000_6000, 4'b1111, 32'h0, 1'b0});
    send(OpLw, 1'b1, 5'd16, 32'h0, 32'h0, 32'h0000_6000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    dm_ack_i   = 1'b1;
    dm_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    check("abort_req", {31'h0, dm_req_o}, 32'h0);
    check("abort_stall", {31'h0, stall_req_o}, 32'h0);
    check("abort_wb", {wreg_o, waddr_o, wdata_o[25:0]}, 32'h0);
    check("abort_wdata", wdata_o, 32'h0);
    @(posedge clk);
    #1;
    dm_ack_i   = 1'b0;
    dm_rdata_i = 32'h0;
    @(negedge clk);
    check("abort_ack_ignored", {30'h0, wreg_o, dm_req_o}, 32'h0);
    idle(2);

    // Misaligned LW at 0x1002
`ifdef MEM_ALIGN_CHECK_EN
    send(OpLw, 1'b1, 5'd15, 32'h0, 32'h0, 32'h0000_1002);
    idle(3);
    check("align_pulses", align_cnt, 1);
`else
    req_q.push_back('{1'b0, 32'h0000_1000, 4'b1111, 32'h0, 1'b0});
    wb_q.push_back('{5'd15, 32'h0102_0304, 1'b0});
    send(OpLw, 1'b1, 5'd15, 32'h0, 32'h0, 32'h0000_1002);
    ack_after(1, 32'h0102_0304, st);
    idle(3);
    check("align_pulses", align_cnt, 0);
`endif

    idle(2);
    check("wb_queue_drained", wb_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the five-stage MIPS pipeline, directly downstream of `ex`. It registers the EX/MEM pipeline fields each cycle and passes ALU results through to write-back. For load/store ops it drives a request/acknowledge data-memory port, stalls the pipeline until the access completes, and returns load data already lane-selected and sign/zero-extended. It is big-endian: byte address offset 0 maps to bits 31:24.

## Interface
Parameters:
- none; widths are fixed by `define.v`: RegBus 32, RegAddrBus 5, AluOpBus 8.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `wreg_i` in 1: write-enable from `ex`.
- `waddr_i` in 5: destination register from `ex`.
- `wdata_i` in 32: ALU or link result from `ex`.
- `aluop_i` in 8: operation code from `ex`.
- `reg2_i` in 32: store data source.
- `mem_addr_i` in 32: effective address, base + sext(offset).
- `stall_req_o` out 1: hold request to the pipeline controller.
- `dm_req_o` out 1: data-memory request.
- `dm_we_o` out 1: 1 = store.
- `dm_addr_o` out 32: word-aligned address, {addr[31:2],2'b00}.
- `dm_sel_o` out 4: byte lane enables; bit 3 = bits 31:24.
- `dm_wdata_o` out 32: store data.
- `dm_ack_i` in 1: access complete; `dm_rdata_i` is valid in the same cycle.
- `dm_rdata_i` in 32: load data.
- `wreg_o`, `waddr_o` (5), `wdata_o` (32) out: registered MEM/WB fields.
- `align_err_o` out 1: misaligned-access pulse. See Configuration.

## Operation
- Stage registers capture the six `ex` fields on each edge where `stall_req_o` is 0.
- Memory ops are EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP. All other aluop values are pass-through.
- FSM states:
  - IDLE → ACCESS on the edge that captures a memory op.
  - ACCESS → IDLE on the edge where `dm_ack_i` is 1.
- In ACCESS, `dm_req_o` is 1, and `dm_addr_o`, `dm_sel_o`, `dm_we_o`, `dm_wdata_o` are held constant from the stage registers.
- Lanes, where a = addr[1:0]:
  - Byte ops: sel = 1000 >> a.
  - Halfword ops: sel = 1100 when a[1]=0, else 0011.
  - Word ops: sel = 1111.
- Store data:
  - SB: reg2[7:0] replicated ×4.
  - SH: reg2[15:0] replicated ×2.
  - SW: reg2 unchanged.
- Load result:
  - LB/LBU: the selected byte, sign- or zero-extended.
  - LH/LHU: the selected halfword, sign- or zero-extended.
  - LW: `dm_rdata_i` unchanged.
- `stall_req_o` = (state==ACCESS) && !`dm_ack_i`. This is combinational on the ack.
- Output registers update every edge:
  - IDLE with a pass-through op: take the stage fields unchanged.
  - ACCESS without ack: bubble, `wreg_o`=0, `wdata_o`=0.
  - ACCESS with ack, load: `wreg_o`=wreg_q, `waddr_o`=waddr_q, `wdata_o` = load result.
  - ACCESS with ack, store: `wreg_o`=0.

## Timing
- Reset: state IDLE. Every output, stage register and output register is 0.
- Reset during ACCESS aborts the access. `dm_req_o` is 0 from the cycle after the reset edge. An ack arriving in IDLE is ignored.
- Pass-through latency: captured at edge k, visible on `*_o` after edge k+1.
- Memory op captured at edge k:
  - `dm_req_o` is high from k until the ack edge j, where j ≥ k+1.
  - The result is visible after edge j.
  - `stall_req_o` is high in cycles k..j-1 except the ack cycle.
- When the ack and the next `ex` op coincide, the next op is captured at edge j. Back-to-back memory ops re-enter ACCESS at j with no idle cycle.
- Ack with zero wait: this cannot occur, because the request is visible only after edge k.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A misaligned access is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00.
  - Such an access never enters ACCESS and issues no request.
  - The output registers take a bubble (`wreg_o`=0).
  - `align_err_o` is 1 for exactly the cycle after the capture edge.
- `MEM_ALIGN_CHECK_EN` undefined:
  - `align_err_o` is tied to 0.
  - Halfword ops ignore addr[0]; word ops ignore addr[1:0]. The access proceeds normally.

## Test plan
- ADD with `wreg_i`=1, `waddr_i`=5, `wdata_i`=0x12345678 → after the next edge `wreg_o`=1, `waddr_o`=5, `wdata_o`=0x12345678; `stall_req_o` stays 0.
- LB at 0x00001001, ack after 3 cycles, rdata 0x11803344 → `dm_sel_o`=0100, `dm_addr_o`=0x00001000, `stall_req_o` high for 2 cycles, `wdata_o`=0xFFFFFF80.
- SH with reg2=0x0000BEEF at 0x00002002 → `dm_we_o`=1, sel 0011, `dm_wdata_o`=0xBEEFBEEF, `wreg_o`=0 after the ack.
- LHU at 0x00002000, rdata 0x8001AAAA → `wdata_o`=0x00008001; with a non-memory op queued behind it, that op appears on the outputs the edge after the load result.
- `rst` pulsed during ACCESS, then `dm_ack_i`=1 one cycle later → `dm_req_o`=0, all outputs 0, no register write.
- LW at 0x00001002 → with `MEM_ALIGN_CHECK_EN`: `align_err_o` pulses once, `dm_req_o` stays 0, `wreg_o`=0. Without it: request to 0x00001000 with sel 1111.
